// File: rtl/ext_bus_if_pkg.sv
// Shared encodings and constants for the ext_bus_if memory-side bus sequencer.
package ext_bus_if_pkg;

   localparam int         CTR_W         = 5;
   localparam logic       DIR_RD        = 1'b0;
   localparam logic       DIR_WR        = 1'b1;
   localparam logic [7:0] IDLE_DATA_DEF = 8'hFF;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_SETUP  = 2'd1,
      ST_STROBE = 2'd2,
      ST_HOLD   = 2'd3
   } state_e;

endpackage

// File: rtl/ext_bus_if_bus_wait_ctr.sv
// Strobe-phase cycle counter: counts strobe-active cycles and flags the
// minimum-wait and timeout thresholds for the bus sequencer.
module ext_bus_if_bus_wait_ctr
   import ext_bus_if_pkg::*;
#(
   parameter int WAIT_MIN = 1,
   parameter int TIMEOUT  = 15
)
(
   input  logic clk,
   input  logic rst_n,
   input  logic clr,
   input  logic en,
   output logic min_met,
   output logic timed_out
);

   localparam logic [CTR_W-1:0] WAIT_MIN_C = CTR_W'(WAIT_MIN);
   localparam logic [CTR_W-1:0] TIMEOUT_C  = CTR_W'(TIMEOUT);

   logic [CTR_W-1:0] cnt_r;

   // Count strobe cycles; hold at TIMEOUT so a long stall can never wrap into a false min_met.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_r <= {CTR_W{1'b0}};
      end else if (clr) begin
         cnt_r <= {CTR_W{1'b0}};
      end else if (en && (cnt_r < TIMEOUT_C)) begin
         cnt_r <= cnt_r + CTR_W'(1);
      end
   end

   assign min_met   = (cnt_r >= WAIT_MIN_C);
   assign timed_out = (cnt_r >= TIMEOUT_C);

endmodule

// File: rtl/ext_bus_if.sv
// Memory-side bus sequencer: one strobed external read or write per request,
// with wait-state insertion, timeout abort and a latched read-data byte.
module ext_bus_if
   import ext_bus_if_pkg::*;
#(
   parameter int         WAIT_MIN  = 1,
   parameter int         TIMEOUT   = 15,
   parameter logic [7:0] IDLE_DATA = IDLE_DATA_DEF
)
(
   input  logic        CLK,
   input  logic        nRES,
   input  logic        req_rd,
   input  logic        req_wr,
   input  logic [7:0]  adl,
   input  logic [7:0]  adh,
   input  logic [7:0]  DL_out,
   output logic [7:0]  DL_in,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [15:0] A,
   output logic [7:0]  D_o,
   output logic        D_oe,
   input  logic [7:0]  D_i,
   output logic        nCS,
   output logic        nRD,
   output logic        nWR,
   input  logic        ext_ready
);

   state_e state_r;
   logic   dir_r;
   logic   min_met_s;
   logic   timed_out_s;
   logic   ctr_clr_s;
   logic   ctr_en_s;

   // The counter reads 1 in the first strobe cycle, so it already counts during SETUP.
   assign ctr_clr_s = (state_r == ST_IDLE) || (state_r == ST_HOLD);
   assign ctr_en_s  = (state_r == ST_SETUP) || (state_r == ST_STROBE);
   assign busy      = (state_r != ST_IDLE);

   ext_bus_if_bus_wait_ctr #(
      .WAIT_MIN (WAIT_MIN),
      .TIMEOUT  (TIMEOUT)
   ) u_bus_wait_ctr (
      .clk       (CLK),
      .rst_n     (nRES),
      .clr       (ctr_clr_s),
      .en        (ctr_en_s),
      .min_met   (min_met_s),
      .timed_out (timed_out_s)
   );

   // Transaction sequencer with registered bus strobes and completion pulses.
   always_ff @(posedge CLK or negedge nRES) begin
      if (!nRES) begin
         state_r <= ST_IDLE;
         dir_r   <= DIR_RD;
         A       <= 16'h0000;
         D_o     <= 8'h00;
         DL_in   <= 8'h00;
         D_oe    <= 1'b0;
         done    <= 1'b0;
         err     <= 1'b0;
         nCS     <= 1'b1;
         nRD     <= 1'b1;
         nWR     <= 1'b1;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state_r)
            ST_IDLE: begin
               if (req_wr || req_rd) begin
                  A       <= {adh, adl};
                  D_o     <= DL_out;
                  dir_r   <= req_wr ? DIR_WR : DIR_RD;
                  D_oe    <= req_wr;
                  nCS     <= 1'b0;
                  state_r <= ST_SETUP;
               end
            end
            ST_SETUP: begin
               nRD     <= (dir_r == DIR_WR);
               nWR     <= (dir_r != DIR_WR);
               state_r <= ST_STROBE;
            end
            ST_STROBE: begin
               // A ready response wins even in the cycle the timeout is reached.
               if (min_met_s && ext_ready) begin
                  nRD     <= 1'b1;
                  nWR     <= 1'b1;
                  done    <= 1'b1;
                  state_r <= ST_HOLD;
                  if (dir_r == DIR_RD) begin
                     DL_in <= D_i;
                  end
               end else if (timed_out_s) begin
                  nRD     <= 1'b1;
                  nWR     <= 1'b1;
                  done    <= 1'b1;
                  err     <= 1'b1;
                  state_r <= ST_HOLD;
                  if (dir_r == DIR_RD) begin
                     DL_in <= IDLE_DATA;
                  end
               end
            end
            ST_HOLD: begin
               nCS     <= 1'b1;
               D_oe    <= 1'b0;
               state_r <= ST_IDLE;
            end
            default: begin
               nCS     <= 1'b1;
               nRD     <= 1'b1;
               nWR     <= 1'b1;
               D_oe    <= 1'b0;
               state_r <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: doc/ext_bus_if.md
Name: ext_bus_if

Overview:
- Memory-side sequencer for the internal address and data buses.
- Accepts one read or write request per transaction, using the address driven on adl/adh and, for writes, the byte driven on DL.
- Runs a strobed external cycle with wait-state insertion and a timeout.
- Returns read data as a latched byte for the core to gate back onto DL.

Parameters:
WAIT_MIN, 1, minimum strobe-active cycles (1..7)
TIMEOUT, 15, maximum strobe-active cycles before abort (WAIT_MIN < TIMEOUT <= 31)
IDLE_DATA, 8'hFF, value returned on DL_in after a timed-out read

Ports:
CLK  in  1  core clock; all state on rising edge
nRES  in  1  asynchronous active-low reset
req_rd  in  1  read request, sampled in IDLE only
req_wr  in  1  write request, sampled in IDLE only
adl  in  8  address low byte, captured at accept
adh  in  8  address high byte, captured at accept
DL_out  in  8  write data, captured at accept
DL_in  out  8  read data latch, valid from done onward
busy  out  1  high from the accept cycle+1 through the done cycle
done  out  1  one-cycle pulse at end of transaction
err  out  1  one-cycle pulse with done on timeout
A  out  16  external address {adh,adl}
D_o  out  8  external write data
D_oe  out  1  external data drive enable
D_i  in  8  external read data
nCS  out  1  external chip select, active low
nRD  out  1  external read strobe, active low
nWR  out  1  external write strobe, active low
ext_ready  in  1  external wait input, high = complete

Behaviour:
- Reset (nRES low, immediate): state IDLE; A=0, D_o=0, DL_in=8'h00; D_oe=0, busy=0, done=0, err=0; nCS=nRD=nWR=1; wait counter=0.
- Reset asserted mid-transaction aborts at once: strobes deassert, no done pulse, DL_in cleared to 8'h00.
- FSM states: IDLE, SETUP, STROBE, HOLD.
- IDLE:
  - On req_wr or req_rd: capture A, D_o and the direction bit; go to SETUP.
  - If both are high, write wins; the read is dropped with no error.
  - Requests outside IDLE are ignored, not queued.
- SETUP (1 cycle):
  - nCS=0; D_oe=1 if write.
  - Counter cleared.
  - Go to STROBE.
- STROBE:
  - nCS=0, plus nRD=0 (read) or nWR=0 (write); D_oe held for write.
  - Counter increments each cycle.
  - Leave when counter >= WAIT_MIN and ext_ready=1. On a read, D_i is captured into DL_in on that same edge.
  - If the counter reaches TIMEOUT with ext_ready still low: leave, set the err flag, and on a read load DL_in=IDLE_DATA.
- HOLD (1 cycle):
  - Strobes high, nCS=0, D_oe still 1 for write (data hold).
  - done=1, and err=1 if flagged.
  - Next state IDLE, releasing nCS and D_oe.
- A request in the cycle right after HOLD is accepted normally (back-to-back allowed).
- Latency: accept at edge 0, done high during cycle 2+WAIT_MIN+n (n = extra ready-low cycles). With WAIT_MIN=1 and ready high: SETUP, STROBE, HOLD = 3 cycles.
- busy:
  - Combinational from state != IDLE.
  - Core logic must hold the request off while busy.
- DL_in keeps its value until the next completed read; writes never change it.
- Counter is 5 bits and saturates at TIMEOUT; it never wraps.
- A and D_o stay stable for the whole transaction and keep their last value in IDLE.

Decomposition:
- Shared package:
  - FSM state encoding (IDLE=2'd0, SETUP=2'd1, STROBE=2'd2, HOLD=2'd3)
  - the direction bit constant
  - the IDLE_DATA default
  - the counter width constant (5)
- One natural sub-module, bus_wait_ctr:
  - saturating strobe counter with clear/enable
  - outputs min_met and timed_out

Test Plan:
- Reset then read: adh=8'hC0, adl=8'h12, D_i=8'h5A, ext_ready=1, WAIT_MIN=1 -> A=16'hC012; nRD low exactly 1 cycle; done at cycle 3; DL_in=8'h5A; err=0.
- Write: adh=8'hFF, adl=8'h80, DL_out=8'h3C, ext_ready=1 -> D_o=8'h3C; D_oe high for SETUP through HOLD; nWR low 1 cycle; DL_in unchanged.
- Wait states: read, ext_ready low 4 STROBE cycles then high, D_i=8'hA5 -> nRD low 5 cycles; done 4 cycles later than baseline; DL_in=8'hA5.
- Timeout: read, ext_ready stuck low, TIMEOUT=15 -> nRD low 15 cycles; done and err pulse together; DL_in=8'hFF; next read succeeds normally.
- Simultaneous/busy:
  - req_rd and req_wr together -> write cycle only.
  - New req_rd during STROBE -> ignored; no second transaction.
- Reset mid-STROBE: nRES low during a write -> nWR, nCS, D_oe release within the same cycle; no done; busy=0 after release.
